// File: rtl/dma_copy_engine.sv
// dma_copy_engine
//   Bus initiator that copies a block of words from a source word address to a
//   destination word address. Each word takes one read cycle and then one write
//   cycle. The engine asks the CPU-side arbiter for the bus with o_BusReq and
//   waits for i_BusGnt. Any cycle without grant pauses the engine in its
//   current state.
//
//   Optional feature (macro DMA_FILL_EN): adds i_Fill and i_Pattern. With the
//   latched fill bit set, the engine writes the latched pattern to every
//   destination word and never issues a read cycle.
//
// Ports
//   Clk        clock, rising edge
//   Reset      asynchronous, active-low reset
//   i_Start    start request, sampled only while idle
//   i_Src      source start word address
//   i_Dst      destination start word address
//   i_Count    number of words to copy (0 completes with no bus activity)
//   i_Fill     (DMA_FILL_EN) fill mode select, latched at start
//   i_Pattern  (DMA_FILL_EN) fill pattern, latched at start
//   o_Busy     high in every state except idle
//   o_Done     one-cycle completion pulse
//   o_BusReq   bus request to the arbiter
//   i_BusGnt   bus grant from the arbiter
//   o_A        bus word address
//   o_WE       bus write enable
//   o_D        bus write data
//   i_D        bus read data, combinational, valid in the same cycle as o_A
module dma_copy_engine #(
   parameter int unsigned CNT_W = 6
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             i_Start,
   input  logic [31:0]      i_Src,
   input  logic [31:0]      i_Dst,
   input  logic [CNT_W-1:0] i_Count,
`ifdef DMA_FILL_EN
   input  logic             i_Fill,
   input  logic [31:0]      i_Pattern,
`endif
   output logic             o_Busy,
   output logic             o_Done,
   output logic             o_BusReq,
   input  logic             i_BusGnt,
   output logic [31:0]      o_A,
   output logic             o_WE,
   output logic [31:0]      o_D,
   input  logic [31:0]      i_D
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      src_q, dst_q, data_q;
   logic [CNT_W-1:0] rem_q;
   logic             load, rd_cap, wr_adv;
   logic             fill_mode;
   logic [31:0]      wr_data;

`ifdef DMA_FILL_EN
   logic             fill_q;
   logic [31:0]      pat_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         fill_q <= 1'b0;
         pat_q  <= '0;
      end else if (load) begin
         fill_q <= i_Fill;
         pat_q  <= i_Pattern;
      end
   end

   assign fill_mode = fill_q;
   assign wr_data   = fill_q ? pat_q : data_q;
`else
   assign fill_mode = 1'b0;
   assign wr_data   = data_q;
`endif

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state  <= S_IDLE;
         src_q  <= '0;
         dst_q  <= '0;
         data_q <= '0;
         rem_q  <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            src_q <= i_Src;
            dst_q <= i_Dst;
            rem_q <= i_Count;
         end
         if (rd_cap) begin
            data_q <= i_D;
            src_q  <= src_q + 32'd1;
         end
         if (wr_adv) begin
            dst_q <= dst_q + 32'd1;
            rem_q <= rem_q - CNT_W'(1);
         end
      end
   end

   // Bus outputs are decoded from state and registers; o_WE follows grant
   // directly so that a grant drop in WRITE never produces a write strobe.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      rd_cap    = 1'b0;
      wr_adv    = 1'b0;
      o_BusReq  = 1'b0;
      o_Done    = 1'b0;
      o_A       = '0;
      o_WE      = 1'b0;
      o_D       = '0;
      unique case (state)
         S_IDLE: begin
            if (i_Start) begin
               if (i_Count != '0) begin
                  load      = 1'b1;
                  state_nxt = S_REQ;
               end else begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_REQ: begin
            o_BusReq = 1'b1;
            if (i_BusGnt)
               state_nxt = fill_mode ? S_WRITE : S_READ;
         end
         S_READ: begin
            o_BusReq = 1'b1;
            o_A      = src_q;
            if (i_BusGnt) begin
               rd_cap    = 1'b1;
               state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            o_BusReq = 1'b1;
            o_A      = dst_q;
            o_D      = wr_data;
            o_WE     = i_BusGnt;
            if (i_BusGnt) begin
               wr_adv = 1'b1;
               if (rem_q == CNT_W'(1))
                  state_nxt = S_DONE;
               else
                  state_nxt = fill_mode ? S_WRITE : S_READ;
            end
         end
         S_DONE: begin
            o_Done    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign o_Busy = (state != S_IDLE);

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine
//   Self-checking bench for dma_copy_engine. A 64-word memory (address taken
//   modulo 64) sits on the bus. Expected write streams, final memory images and
//   completion cycles come from a word-by-word block-copy model and from
//   counting granted cycles.
module tb_dma_copy_engine;
   localparam int unsigned CNT_W = 6;

   logic             Clk = 1'b0;
   logic             Reset = 1'b0;
   logic             i_Start = 1'b0;
   logic [31:0]      i_Src = '0;
   logic [31:0]      i_Dst = '0;
   logic [CNT_W-1:0] i_Count = '0;
`ifdef DMA_FILL_EN
   logic             i_Fill = 1'b0;
   logic [31:0]      i_Pattern = '0;
`endif
   logic             o_Busy, o_Done, o_BusReq, o_WE;
   logic             i_BusGnt = 1'b0;
   logic [31:0]      o_A, o_D, i_D;

   logic [31:0] mem [64];
   logic [63:0] wlog [$];
   logic [31:0] atrace [$];
   logic        gnt_q [$];

   logic        s_done, s_req, s_we, s_busy;
   logic [31:0] s_a, s_d;

   int unsigned n_pass = 0;
   int unsigned n_tot  = 0;

   dma_copy_engine #(.CNT_W(CNT_W)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .i_Start  (i_Start),
      .i_Src    (i_Src),
      .i_Dst    (i_Dst),
      .i_Count  (i_Count),
`ifdef DMA_FILL_EN
      .i_Fill   (i_Fill),
      .i_Pattern(i_Pattern),
`endif
      .o_Busy   (o_Busy),
      .o_Done   (o_Done),
      .o_BusReq (o_BusReq),
      .i_BusGnt (i_BusGnt),
      .o_A      (o_A),
      .o_WE     (o_WE),
      .o_D      (o_D),
      .i_D      (i_D)
   );

   always #5 Clk = ~Clk;

   assign i_D = mem[o_A[5:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One bus cycle: drive grant, sample at the falling edge, commit any write.
   task automatic tick(input logic g);
      i_BusGnt = g;
      @(negedge Clk);
      s_done = o_Done; s_req = o_BusReq; s_we = o_WE; s_busy = o_Busy;
      s_a = o_A; s_d = o_D;
      chk("we_without_gnt", {31'd0, o_WE & ~g}, 32'd0);
      if (o_WE) begin
         mem[o_A[5:0]] = o_D;
         wlog.push_back({o_A, o_D});
      end
      @(posedge Clk); #1;
   endtask

   task automatic start(input logic [31:0] src, input logic [31:0] dst,
                        input int unsigned cnt, input logic fill, input logic [31:0] pat);
      i_Src = src; i_Dst = dst; i_Count = cnt[CNT_W-1:0];
`ifdef DMA_FILL_EN
      i_Fill = fill; i_Pattern = pat;
`else
      if (fill) $display("fill requested without DMA_FILL_EN, pattern %h ignored", pat);
`endif
      i_Start = 1'b1;
      @(posedge Clk); #1;
      i_Start = 1'b0;
   endtask

   // Completion cycle from the grant sequence: REQ needs one granted cycle,
   // each word needs one (fill) or two (copy) more; done follows the last one.
   function automatic int unsigned model_done(input int unsigned cnt, input logic fill);
      int unsigned need, got;
      need = (cnt == 0) ? 0 : (fill ? 1 + cnt : 1 + 2 * cnt);
      if (need == 0) return 1;
      got = 0;
      for (int unsigned k = 0; k < 2000; k++) begin
         if (k >= gnt_q.size() || gnt_q[k]) got++;
         if (got == need) return k + 2;
      end
      return 0;
   endfunction

   task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst,
                           input int unsigned cnt, input logic fill, input logic [31:0] pat,
                           input int unsigned exp_done, input string tag);
      logic [31:0] m [64];
      logic [63:0] exp_w [$];
      logic [31:0] a, d;
      int unsigned done_cyc, bad;
      logic g;
      m = mem;
      for (int unsigned i = 0; i < cnt; i++) begin
         a = src + i;
         d = fill ? pat : m[a[5:0]];
         a = dst + i;
         m[a[5:0]] = d;
         exp_w.push_back({a, d});
      end
      wlog.delete();
      atrace.delete();
      start(src, dst, cnt, fill, pat);
      done_cyc = 0;
      for (int unsigned c = 1; c <= 400 && done_cyc == 0; c++) begin
         g = (gnt_q.size() != 0) ? gnt_q.pop_front() : 1'b1;
         // Start requests and parameter changes while busy must be ignored.
         i_Start = 1'($urandom); i_Src = $urandom; i_Dst = $urandom;
         i_Count = CNT_W'($urandom);
         tick(g);
         atrace.push_back(s_a);
         chk({tag, "_busy"}, {31'd0, s_busy}, 32'd1);
         if (cnt == 0) chk({tag, "_no_bus"}, {31'd0, s_req | s_we}, 32'd0);
         if (s_done) begin
            done_cyc = c;
            chk({tag, "_req_in_done"}, {31'd0, s_req}, 32'd0);
         end
      end
      i_Start = 1'b0;
      gnt_q.delete();
      chk({tag, "_done_cycle"}, done_cyc, exp_done);
      tick(1'b1);
      chk({tag, "_idle_after"}, {30'd0, s_busy, s_done}, 32'd0);
      chk({tag, "_nwrites"}, wlog.size(), exp_w.size());
      for (int unsigned i = 0; i < exp_w.size() && i < wlog.size(); i++) begin
         chk({tag, "_waddr"}, wlog[i][63:32], exp_w[i][63:32]);
         chk({tag, "_wdata"}, wlog[i][31:0], exp_w[i][31:0]);
      end
      bad = 0;
      for (int unsigned i = 0; i < 64; i++) if (mem[i] !== m[i]) bad++;
      chk({tag, "_mem_image"}, bad, 0);
   endtask

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int unsigned cnt;
      int unsigned exp_done;
   } vec_t;

   initial begin
      vec_t vecs [6];
      logic [31:0] rs, rd;
      int unsigned rc, ed;
      logic rf;

      vecs[0] = '{32'd0,        32'd8,  3, 8};
      vecs[1] = '{32'd5,        32'd20, 0, 1};
      vecs[2] = '{32'd5,        32'd7,  4, 10};
      vecs[3] = '{32'd30,       32'd27, 5, 12};
      vecs[4] = '{32'd63,       32'd0,  1, 4};
      vecs[5] = '{32'hFFFFFFFF, 32'd10, 2, 6};

      for (int unsigned i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33;

      tick(1'b1);
      chk("rst_busy_done_req_we", {28'd0, o_Busy, o_Done, o_BusReq, o_WE}, 32'd0);
      chk("rst_addr", o_A, 32'd0);
      chk("rst_data", o_D, 32'd0);
      Reset = 1'b1;
      tick(1'b1);

      for (int unsigned v = 0; v < 6; v++) begin
         run_xfer(vecs[v].src, vecs[v].dst, vecs[v].cnt, 1'b0, 32'd0, vecs[v].exp_done, "vec");
         if (v == 0) begin
            chk("v0_mem8", mem[8], 32'd11);
            chk("v0_mem9", mem[9], 32'd22);
            chk("v0_mem10", mem[10], 32'd33);
         end
         if (v == 5) begin
            chk("wrap_read0", atrace[1], 32'hFFFFFFFF);
            chk("wrap_read1", atrace[3], 32'h00000000);
         end
      end

      // Grant low 3 cycles in REQ, then 2 cycles in the first WRITE.
      gnt_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      run_xfer(32'd0, 32'd4, 2, 1'b0, 32'd0, 11, "gnt_pause");

      // Reset during the WRITE of word 1 of a 4-word copy.
      wlog.delete();
      start(32'd0, 32'd40, 4, 1'b0, 32'd0);
      for (int unsigned c = 1; c <= 4; c++) tick(1'b1);
      Reset = 1'b0;
      #1;
      chk("abort_busy_done_req_we", {28'd0, o_Busy, o_Done, o_BusReq, o_WE}, 32'd0);
      chk("abort_addr", o_A, 32'd0);
      chk("abort_data", o_D, 32'd0);
      for (int unsigned c = 0; c < 3; c++) begin
         tick(1'b1);
         chk("abort_no_done", {31'd0, s_done}, 32'd0);
      end
      chk("abort_nwrites", wlog.size(), 1);
      Reset = 1'b1;
      tick(1'b1);
      run_xfer(32'd3, 32'd50, 3, 1'b0, 32'd0, 8, "after_abort");

`ifdef DMA_FILL_EN
      run_xfer(32'd0, 32'd16, 4, 1'b1, 32'hA5A5A5A5, 6, "fill");
      chk("fill_first_addr", atrace[1], 32'd16);
`endif

      for (int unsigned r = 0; r < 25; r++) begin
         rs = $urandom; rd = $urandom; rc = $urandom_range(0, 12);
`ifdef DMA_FILL_EN
         rf = 1'($urandom);
`else
         rf = 1'b0;
`endif
         for (int unsigned k = 0; k < 120; k++) gnt_q.push_back($urandom_range(0, 3) != 0);
         ed = model_done(rc, rf);
         run_xfer(rs, rd, rc, rf, $urandom, ed, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
Bus initiator for the data-memory/GPIO address space. It drives the address, write-enable and write-data lines and consumes read data. It copies a block of words from a source word address to a destination word address, one read cycle followed by one write cycle per word. It arbitrates with the CPU through a request/grant pair, and the bus mux in front of the data memory selects this block while grant is high.

Parameters:
CNT_W, 6, width of the word-count input and the remaining-count register (maximum block 2^CNT_W-1 words)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-low reset
i_Start  input  1  start request, sampled only in IDLE
i_Src  input  32  source start word address
i_Dst  input  32  destination start word address
i_Count  input  CNT_W  number of words to copy
o_Busy  output  1  high in every state except IDLE
o_Done  output  1  one-cycle pulse when a transfer completes
o_BusReq  output  1  bus request to the CPU-side arbiter
i_BusGnt  input  1  bus grant from the arbiter
o_A  output  32  bus address (word index)
o_WE  output  1  bus write enable
o_D  output  32  bus write data
i_D  input  32  bus read data (combinational read, valid in the same cycle as o_A)

Behaviour:
- Reset (Reset=0, asynchronous):
  - state IDLE
  - src, dst and data registers 0; remaining count 0
  - all outputs 0
  - Reset mid-transfer aborts with no o_Done and no further write.
- States: IDLE, REQ, READ, WRITE, DONE.
- IDLE:
  - o_BusReq=0.
  - i_Start=1 and i_Count!=0: latch i_Src, i_Dst, i_Count; go to REQ.
  - i_Start=1 and i_Count=0: go to DONE directly; no bus request, no bus activity.
- REQ:
  - o_BusReq=1.
  - i_BusGnt=1 at the clock edge: go to READ. Otherwise stay in REQ.
- READ:
  - o_BusReq=1, o_A=src, o_WE=0.
  - If i_BusGnt=1 at the edge: capture i_D into the data register, src<=src+1, go to WRITE.
  - If i_BusGnt=0: stay in READ with nothing captured (pause).
- WRITE:
  - o_BusReq=1, o_A=dst, o_D=data register, o_WE=i_BusGnt.
  - If i_BusGnt=1 at the edge: dst<=dst+1, remaining<=remaining-1. Go to DONE if remaining was 1, else READ.
  - If i_BusGnt=0: stay in WRITE, o_WE=0 (pause).
- DONE: o_Done=1 and o_BusReq=0 for exactly one cycle; then IDLE.
- Outside READ/WRITE: o_A=0, o_WE=0, o_D=0. Bus outputs are combinational from state and registers.
- Latency with grant held high: Start edge → REQ (1 cycle) → 2N cycles of READ/WRITE → DONE (1 cycle).
  - o_Done is asserted in cycle 2N+2 after the Start edge.
- Address arithmetic is 32-bit modulo 2^32; 32'hFFFFFFFF increments to 0, with no error flag.
- i_Start while o_Busy=1 is ignored; the latched parameters are not disturbed.
- Overlapping src/dst ranges are copied strictly in ascending order. Forward overlap therefore replicates data; this is intended behaviour.
- Grant may drop and return any number of times. The transfer resumes in the same state with no word skipped or duplicated.

Optional Feature:
- Macro: DMA_FILL_EN.
- Defined:
  - Extra inputs i_Fill (1 bit) and i_Pattern (32 bits), latched at Start.
  - With the latched fill bit set: REQ → WRITE directly, WRITE → WRITE per word, READ is never entered, and o_D=latched pattern.
  - Completion in cycle N+2 after Start.
  - i_Fill=0 behaves as copy mode.
- Undefined: ports i_Fill and i_Pattern are absent; the block is copy-only.

Test Plan:
- Preload mem[0..2]=11,22,33; Src=0, Dst=8, Count=3, grant tied high.
  - Writes occur to 8, 9, 10 with data 11, 22, 33.
  - o_Done pulses in cycle 8 after Start; o_BusReq=0 in DONE.
- Count=0 with Start → o_Done one cycle later; o_BusReq and o_WE never assert.
- Src=0, Dst=4, Count=2; grant low for 3 cycles in REQ, then low for 2 cycles while in WRITE of word 0.
  - o_WE=0 during the low-grant cycles.
  - Exactly two writes occur, to 4 and 5 with correct data.
  - o_Done is delayed by 5 cycles.
- Src=32'hFFFFFFFF, Count=2 → reads at addresses FFFFFFFF then 00000000.
- Reset asserted in WRITE of word 1 of a Count=4 transfer → outputs 0 immediately; no o_Done. After release, a new Start runs normally.
- DMA_FILL_EN: Fill=1, Pattern=32'hA5A5A5A5, Dst=16, Count=4 → four consecutive write cycles to 16..19; no read cycles; o_Done in cycle 6 after Start.
